vga_timing_controller: RTL

//  Sequences one full video frame: a horizontal pixel counter and a vertical line counter.

---
 rtl/vga_timing_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_controller
// Description : Frame sequencer for a pixel-clock video pipe. A horizontal
//               pixel counter and a vertical line counter are decoded against
//               programmable compare points into blank, hsync and vsync.
//               The host writes shadow timing registers; a commit makes them
//               active atomically at the next frame wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_controller #(
  parameter int   C         = 10,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   H_S_BLANK = 640,
  parameter int   H_S_SYNC  = 656,
  parameter int   H_R_SYNC  = 752,
  parameter int   H_TOTAL   = 800,
  parameter int   V_S_BLANK = 480,
  parameter int   V_S_SYNC  = 490,
  parameter int   V_R_SYNC  = 492,
  parameter int   V_TOTAL   = 525
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [C-1:0] cfg_data,
  input  logic         cfg_commit,
  output logic         cfg_pending,
  output logic [C-1:0] h_count,
  output logic [C-1:0] v_count,
  output logic         blank,
  output logic         hsync,
  output logic         vsync,
  output logic         line_start,
  output logic         frame_start
);

  // Register file indices (cfg_addr map)
  localparam int R_H_S_BLANK = 0;
  localparam int R_H_S_SYNC  = 1;
  localparam int R_H_R_SYNC  = 2;
  localparam int R_H_TOTAL   = 3;
  localparam int R_V_S_BLANK = 4;
  localparam int R_V_S_SYNC  = 5;
  localparam int R_V_R_SYNC  = 6;
  localparam int R_V_TOTAL   = 7;

  localparam logic [C-1:0] ONE = C'(1);

  function automatic logic [C-1:0] reg_default(input int idx);
    case (idx)
      R_H_S_BLANK: return C'(H_S_BLANK);
      R_H_S_SYNC:  return C'(H_S_SYNC);
      R_H_R_SYNC:  return C'(H_R_SYNC);
      R_H_TOTAL:   return C'(H_TOTAL);
      R_V_S_BLANK: return C'(V_S_BLANK);
      R_V_S_SYNC:  return C'(V_S_SYNC);
      R_V_R_SYNC:  return C'(V_R_SYNC);
      default:     return C'(V_TOTAL);
    endcase
  endfunction

  logic [C-1:0] act_q   [8];
  logic [C-1:0] shd_q   [8];
  logic [C-1:0] act_nxt [8];

  logic [C-1:0] h_lim;
  logic [C-1:0] v_lim;
  logic [C-1:0] h_nxt;
  logic [C-1:0] v_nxt;
  logic         h_wrap;
  logic         f_wrap;
  logic         apply;
  logic         blank_nxt;
  logic         hs_on;
  logic         vs_on;

  // Next counts, commit decision and decodes of the post-edge state, so the
  // registered outputs line up with the counts they describe
  always_comb begin
    // A total of zero is treated as one: the limit saturates at 0
    h_lim = (act_q[R_H_TOTAL] == '0) ? '0 : act_q[R_H_TOTAL] - ONE;
    v_lim = (act_q[R_V_TOTAL] == '0) ? '0 : act_q[R_V_TOTAL] - ONE;

    // ">=" rather than "==" so a total shrunk below the current count still wraps
    h_wrap = (h_count >= h_lim);
    f_wrap = h_wrap && (v_count >= v_lim);

    h_nxt = h_wrap ? '0 : h_count + ONE;
    v_nxt = v_count;
    if (h_wrap) begin
      v_nxt = f_wrap ? '0 : v_count + ONE;
    end

    // A commit arriving on the wrap edge itself is honoured at that wrap
    apply = f_wrap && (cfg_pending || cfg_commit);
    for (int i = 0; i < 8; i++) begin
      act_nxt[i] = apply ? shd_q[i] : act_q[i];
    end

    blank_nxt = (h_nxt >= act_nxt[R_H_S_BLANK]) || (v_nxt >= act_nxt[R_V_S_BLANK]);
    hs_on     = (h_nxt >= act_nxt[R_H_S_SYNC]) && (h_nxt < act_nxt[R_H_R_SYNC]);
    vs_on     = (v_nxt >= act_nxt[R_V_S_SYNC]) && (v_nxt < act_nxt[R_V_R_SYNC]);
  end

  // Counters, active timing set, pending flag and registered decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count     <= '0;
      v_count     <= '0;
      blank       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      cfg_pending <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        act_q[i] <= reg_default(i);
      end
    end else if (en) begin
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      blank       <= blank_nxt;
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      line_start  <= h_wrap;
      frame_start <= f_wrap;
      if (apply) begin
        cfg_pending <= 1'b0;
      end else if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        act_q[i] <= act_nxt[i];
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  // Host shadow registers; writable regardless of en. The copy into the
  // active set reads the pre-write value, so a coincident write stays here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shd_q[i] <= reg_default(i);
      end
    end else if (cfg_we) begin
      shd_q[cfg_addr] <= cfg_data;
    end
  end

endmodule
`default_nettype wire
